// File: rtl/bootrom_sched.sv
// Boot ROM scheduler: shares one ROM read port between CPU and host,
// and owns the boot overlay flag that maps the ROM at address 0.
module bootrom_sched #(
  parameter int unsigned HOST_MAXWAIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [9:0]  cpu_addr,
  output logic        cpu_ack,
  output logic [15:0] cpu_data,
  input  logic        host_req,
  input  logic [9:0]  host_addr,
  output logic        host_ack,
  output logic [15:0] host_data,
  input  logic        ovl_clr,
  input  logic        host_reboot,
  output logic        ovl,
  output logic        rom_aen,
  output logic        rom_rd,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    ACK
  } state_t;

  localparam logic [7:0] MAXW = 8'(HOST_MAXWAIT);

  state_t     state;
  state_t     state_nx;
  logic       gnt_host;
  logic [7:0] starve;
  logic       cpu_win;
  logic       host_win;

  always_comb begin
    state_nx = state;
    cpu_win  = 1'b0;
    host_win = 1'b0;
    unique case (state)
      IDLE: begin
        host_win = host_req &&
                   (!cpu_req || starve >= MAXW);
        cpu_win  = cpu_req && !host_win;
        if (cpu_win || host_win)
          state_nx = RD;
      end
      RD:      state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt_host  <= 1'b0;
      starve    <= '0;
      ovl       <= 1'b1;
      rom_aen   <= 1'b0;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      cpu_data  <= '0;
      host_data <= '0;
    end else begin
      state    <= state_nx;
      rom_aen  <= 1'b0;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      // reboot dominates a simultaneous clear
      if (host_reboot)
        ovl <= 1'b1;
      else if (ovl_clr)
        ovl <= 1'b0;
      if (cpu_win) begin
        gnt_host <= 1'b0;
        rom_aen  <= ovl;
        rom_rd   <= ovl;
        rom_addr <= ovl ? cpu_addr : '0;
        if (host_req && starve != 8'hFF)
          starve <= starve + 8'd1;
      end
      if (host_win) begin
        gnt_host <= 1'b1;
        rom_aen  <= 1'b1;
        rom_rd   <= 1'b1;
        rom_addr <= host_addr;
        starve   <= '0;
      end
      if (state == RD) begin
        if (gnt_host)
          host_data <= rom_data;
        else
          cpu_data <= rom_aen ? rom_data : '0;
      end
    end
  end

  assign cpu_ack  = (state == ACK) && !gnt_host;
  assign host_ack = (state == ACK) && gnt_host;

endmodule

// File: tb/tb_bootrom_sched.sv
// Bench for bootrom_sched: slot-level reference model, directed
// scenarios and randomized CPU/host/overlay traffic.
module tb_bootrom_sched;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic        cpu_ack;
  logic [15:0] cpu_data;
  logic        host_req = 1'b0;
  logic [9:0]  host_addr = '0;
  logic        host_ack;
  logic [15:0] host_data;
  logic        ovl_clr = 1'b0;
  logic        host_reboot = 1'b0;
  logic        ovl;
  logic        rom_aen;
  logic        rom_rd;
  logic [9:0]  rom_addr;
  logic [15:0] rom_q = '0;

  bootrom_sched #(.HOST_MAXWAIT(MAXW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cpu_req(cpu_req),
    .cpu_addr(cpu_addr),
    .cpu_ack(cpu_ack),
    .cpu_data(cpu_data),
    .host_req(host_req),
    .host_addr(host_addr),
    .host_ack(host_ack),
    .host_data(host_data),
    .ovl_clr(ovl_clr),
    .host_reboot(host_reboot),
    .ovl(ovl),
    .rom_aen(rom_aen),
    .rom_rd(rom_rd),
    .rom_addr(rom_addr),
    .rom_data(rom_q)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];

  // ROM latches the address on the falling edge
  always @(negedge clk)
    rom_q <= (rom_aen && rom_rd) ? mem[rom_addr] : 16'h0000;

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;
  int n_cack = 0;
  int n_hack = 0;
  int cpu_p = 0;
  int host_p = 0;
  int pulse_p = 0;

  // reference: one access occupies a 3-cycle slot (grant, read, ack)
  int          m_slot;
  bit          m_host;
  bit          m_aen;
  bit          m_ovl;
  int          m_cnt;
  logic [9:0]  m_addr;
  logic [15:0] m_cdat;
  logic [15:0] m_hdat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot = 0;
    m_host = 0;
    m_aen  = 0;
    m_ovl  = 1;
    m_cnt  = 0;
    m_addr = '0;
    m_cdat = '0;
    m_hdat = '0;
  endtask

  task automatic model_edge();
    bit hw;
    bit cw;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_slot == 0) begin
      hw = host_req && (!cpu_req || m_cnt >= MAXW);
      cw = cpu_req && !hw;
      if (cw && host_req && m_cnt < 255) m_cnt++;
      if (hw) m_cnt = 0;
      if (hw || cw) begin
        m_slot = 1;
        m_host = hw;
        m_addr = hw ? host_addr : cpu_addr;
        m_aen  = hw || m_ovl;
      end
    end else if (m_slot == 1) begin
      m_slot = 2;
      if (m_host) m_hdat = mem[m_addr];
      else m_cdat = m_aen ? mem[m_addr] : 16'h0000;
    end else begin
      m_slot = 0;
    end
    if (host_reboot) m_ovl = 1;
    else if (ovl_clr) m_ovl = 0;
  endtask

  task automatic check_all();
    bit rd;
    rd = (m_slot == 1) && m_aen;
    chk("cpu_ack", cpu_ack, m_slot == 2 && !m_host);
    chk("host_ack", host_ack, m_slot == 2 && m_host);
    chk("rom_aen", rom_aen, rd);
    chk("rom_rd", rom_rd, rd);
    chk("rom_addr", rom_addr, rd ? m_addr : 10'd0);
    chk("cpu_data", cpu_data, m_cdat);
    chk("host_data", host_data, m_hdat);
    chk("ovl", ovl, m_ovl);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    n_cyc++;
    check_all();
    if (cpu_ack) begin
      cpu_req = 0;
      n_cack++;
    end
    if (host_ack) begin
      host_req = 0;
      n_hack++;
    end
    if (!cpu_req && $urandom_range(99) < cpu_p) begin
      cpu_req  = 1;
      cpu_addr = 10'($urandom);
    end
    if (!host_req && $urandom_range(99) < host_p) begin
      host_req  = 1;
      host_addr = 10'($urandom);
    end
    ovl_clr     = $urandom_range(99) < pulse_p;
    host_reboot = $urandom_range(99) < pulse_p;
  endtask

  task automatic wait_cack(input int maxc, output int lat);
    int c0;
    int s;
    c0 = n_cack;
    s  = n_cyc;
    while (n_cack == c0 && n_cyc - s < maxc) step();
    lat = n_cyc - s;
    chk("cack_timeout", n_cack != c0, 1);
  endtask

  task automatic wait_hack(input int maxc, output int lat);
    int c0;
    int s;
    c0 = n_hack;
    s  = n_cyc;
    while (n_hack == c0 && n_cyc - s < maxc) step();
    lat = n_cyc - s;
    chk("hack_timeout", n_hack != c0, 1);
  endtask

  task automatic drain();
    cpu_p  = 0;
    host_p = 0;
    pulse_p = 0;
    for (int i = 0; i < 20; i++)
      if (cpu_req || host_req || m_slot != 0) step();
  endtask

  initial begin
    int lat;
    int c0;
    int t0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[4] = 16'h5951;
    model_reset();
    repeat (2) step();
    reset_n = 1;
    step();

    // CPU read through the overlay
    cpu_req  = 1;
    cpu_addr = 10'd4;
    wait_cack(10, lat);
    chk("t1_lat", lat, 2);
    chk("t1_data", cpu_data, 16'h5951);
    chk("t1_ovl", ovl, 1);
    step();

    // overlay cleared: ROM disabled, ack still given
    ovl_clr = 1;
    step();
    chk("t2_ovl", ovl, 0);
    cpu_req  = 1;
    cpu_addr = 10'd4;
    wait_cack(10, lat);
    chk("t2_lat", lat, 2);
    chk("t2_data", cpu_data, 16'h0000);
    step();

    // set/clear interplay
    ovl_clr = 1;
    host_reboot = 1;
    step();
    chk("t3_both", ovl, 1);
    ovl_clr = 1;
    step();
    chk("t3_clr", ovl, 0);
    host_reboot = 1;
    step();
    chk("t3_reboot", ovl, 1);

    // starvation bound with CPU hogging the port
    cpu_p = 100;
    cpu_req = 1;
    cpu_addr = 10'($urandom);
    for (int i = 0; i < 5 && m_slot != 0; i++) step();
    host_req  = 1;
    host_addr = 10'($urandom);
    c0 = n_cack;
    wait_hack(60, lat);
    chk("t4_cpu_acks", n_cack - c0, MAXW);
    chk("t4_hdata", host_data, mem[host_addr]);
    wait_cack(10, lat);
    chk("t4_resume", lat, 3);
    drain();

    // simultaneous requests: CPU first, host next slot
    cpu_req   = 1;
    cpu_addr  = 10'($urandom);
    host_req  = 1;
    host_addr = 10'($urandom);
    c0 = n_hack;
    wait_cack(10, lat);
    chk("t5_host_early", n_hack - c0, 0);
    t0 = n_cyc;
    wait_hack(10, lat);
    chk("t5_gap", n_cyc - t0, 3);
    drain();

    // reset in the middle of a read
    ovl_clr = 1;
    step();
    cpu_req  = 1;
    cpu_addr = 10'd4;
    for (int i = 0; i < 5 && m_slot != 1; i++) step();
    chk("t6_in_rd", m_slot, 1);
    c0 = n_cack;
    reset_n = 0;
    #1;
    model_reset();
    chk("t6_ack", cpu_ack, 0);
    chk("t6_ovl", ovl, 1);
    chk("t6_aen", rom_aen, 0);
    repeat (2) step();
    chk("t6_noack", n_cack - c0, 0);
    reset_n = 1;
    wait_cack(10, lat);
    chk("t6_lat", lat, 2);
    chk("t6_data", cpu_data, 16'h5951);
    drain();

    // randomized mixed traffic with overlay pulses
    cpu_p = 40;
    host_p = 30;
    pulse_p = 5;
    repeat (1500) step();
    cpu_p = 95;
    host_p = 60;
    pulse_p = 2;
    repeat (1500) step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
